// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller.
//   - ic_state_e      : call FSM state encodings (IDLE / REQ / SERVICE)
//   - IC_N_IRQ_DEFAULT: default channel count
//   - ic_id_width()   : channel-ID width for a given channel count (min 1)
package interrupt_controller_pkg;

  localparam int IC_N_IRQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_REQ     = 2'd1,
    IC_SERVICE = 2'd2
  } ic_state_e;

  function automatic int ic_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// irq_priority_encoder: fixed-priority encoder, lowest set index wins.
// Ports:
//   req       : N_IRQ-wide request vector (eligible channels)
//   any_valid : 1 when at least one request bit is set
//   winner    : index of the lowest set bit (0 when none set)
module irq_priority_encoder #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_IRQ-1:0] req,
  output logic             any_valid,
  output logic [ID_W-1:0]  winner
);

  always_comb begin
    winner = '0;
    // Scan from the top down so the lowest index is written last.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i);
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: multi-channel interrupt capture, masking and
// fixed-priority call request towards the fetch stage. All state changes on
// the falling edge of i_clk, matching the fetch stage.
// Ports:
//   i_clk, i_reset        : clock (falling-edge active), synchronous active-high reset
//   i_irq                 : raw interrupt lines (edge or level per EDGE_MODE)
//   i_mask                : per-channel enable for raising a call (not for capture)
//   i_enable              : fetch advance; 0 stalls the call FSM
//   i_ack                 : fetch inserted the call for o_irq_id
//   i_done                : handler return retired, ends in-service period
//   o_interrupt_call      : call request to fetch
//   o_irq_id              : channel being requested, valid with o_interrupt_call
//   o_pending, o_overrun  : status: pending bits, sticky overrun bits
//   o_state               : call FSM state (debug)
//
// Handshake: o_interrupt_call is a valid that stays high with o_irq_id frozen
// until it is accepted; acceptance is a falling edge where o_interrupt_call,
// i_ack and i_enable are all 1. i_ack at any other time has no effect.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int               N_IRQ     = IC_N_IRQ_DEFAULT,
  parameter int               ID_W      = ic_id_width(N_IRQ),
  parameter logic [N_IRQ-1:0] EDGE_MODE = {N_IRQ{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic [N_IRQ-1:0] i_mask,
  input  logic             i_enable,
  input  logic             i_ack,
  input  logic             i_done,
  output logic             o_interrupt_call,
  output logic [ID_W-1:0]  o_irq_id,
  output logic [N_IRQ-1:0] o_pending,
  output logic [N_IRQ-1:0] o_overrun,
  output logic [1:0]       o_state
);

  ic_state_e        state, state_next;
  logic             in_service, in_service_next;
  logic             load_id;
  logic [N_IRQ-1:0] prev_irq;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] overrun;
  logic [ID_W-1:0]  irq_id;
  logic [N_IRQ-1:0] trigger;
  logic [N_IRQ-1:0] clear_vec;
  logic [N_IRQ-1:0] eligible;
  logic             any_valid;
  logic [ID_W-1:0]  winner;
  logic             ack_fire;

  // Edge channels fire on a 0->1 of the line; level channels fire while high.
  assign trigger  = (EDGE_MODE & ~prev_irq & i_irq) | (~EDGE_MODE & i_irq);
  assign ack_fire = (state == IC_REQ) && i_enable && i_ack;
  assign clear_vec = ack_fire ? (N_IRQ'(1) << irq_id) : '0;
  assign eligible = pending & i_mask;

  irq_priority_encoder #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio (
    .req       (eligible),
    .any_valid (any_valid),
    .winner    (winner)
  );

  always_comb begin
    state_next      = state;
    in_service_next = in_service;
    load_id         = 1'b0;
    case (state)
      IC_IDLE: begin
        if (i_enable && !in_service && any_valid) begin
          state_next = IC_REQ;
          load_id    = 1'b1;
        end
      end
      IC_REQ: begin
        if (ack_fire) begin
          state_next      = IC_SERVICE;
          in_service_next = 1'b1;
        end
      end
      IC_SERVICE: begin
        if (i_done) begin
          state_next      = IC_IDLE;
          in_service_next = 1'b0;
        end
      end
      default: begin
        state_next      = IC_IDLE;
        in_service_next = 1'b0;
      end
    endcase
  end

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      state      <= IC_IDLE;
      in_service <= 1'b0;
      prev_irq   <= '0;
      pending    <= '0;
      overrun    <= '0;
      irq_id     <= '0;
    end else begin
      state      <= state_next;
      in_service <= in_service_next;
      prev_irq   <= i_irq;
      // A trigger coinciding with the ack of the same channel keeps it pending.
      pending    <= (pending & ~clear_vec) | trigger;
      // Overrun only for edge channels hitting a still-pending, not-just-acked bit.
      overrun    <= overrun | (EDGE_MODE & trigger & pending & ~clear_vec);
      if (load_id) irq_id <= winner;
    end
  end

  assign o_interrupt_call = (state == IC_REQ);
  assign o_irq_id         = irq_id;
  assign o_pending        = pending;
  assign o_overrun        = overrun;
  assign o_state          = state;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller: one edge-mode instance and one
// instance with channel 0 level-triggered. The DUT acts on the falling edge;
// inputs change and outputs are sampled just after the rising edge.
module tb_interrupt_controller;

  logic       clk;
  logic       reset;
  logic [3:0] irq, mask;
  logic       enable, ack, done;
  logic       call;
  logic [1:0] irq_id;
  logic [3:0] pending, overrun;
  logic [1:0] state;

  logic [3:0] lvl_irq;
  logic       lvl_ack, lvl_done;
  logic       lvl_call;
  logic [1:0] lvl_id;
  logic [3:0] lvl_pending, lvl_overrun;
  logic [1:0] lvl_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  interrupt_controller #(.N_IRQ(4), .ID_W(2), .EDGE_MODE(4'b1111)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_irq            (irq),
    .i_mask           (mask),
    .i_enable         (enable),
    .i_ack            (ack),
    .i_done           (done),
    .o_interrupt_call (call),
    .o_irq_id         (irq_id),
    .o_pending        (pending),
    .o_overrun        (overrun),
    .o_state          (state)
  );

  interrupt_controller #(.N_IRQ(4), .ID_W(2), .EDGE_MODE(4'b1110)) dut_lvl (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_irq            (lvl_irq),
    .i_mask           (mask),
    .i_enable         (enable),
    .i_ack            (lvl_ack),
    .i_done           (lvl_done),
    .o_interrupt_call (lvl_call),
    .o_irq_id         (lvl_id),
    .o_pending        (lvl_pending),
    .o_overrun        (lvl_overrun),
    .o_state          (lvl_state)
  );

  // ---------------- driver tasks ----------------
  // One active (falling) edge, then return just after the following rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_call(input string tag, input logic exp_call, input logic [1:0] exp_id);
    check({tag, "_call"}, 32'(call), 32'(exp_call));
    if (exp_call) check({tag, "_id"}, 32'(irq_id), 32'(exp_id));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; irq = '0; mask = 4'hF; enable = 1'b1; ack = 1'b0; done = 1'b0;
    lvl_irq = '0; lvl_ack = 1'b0; lvl_done = 1'b0;
    step(); step();
    check("rst_call",    32'(call),    32'd0);
    check("rst_id",      32'(irq_id),  32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state",   32'(state),   32'd0);
    reset = 1'b0;
    step();

    // Single edge on channel 2: pending same edge, call next edge.
    irq = 4'b0100; step();
    check("t1_pending", 32'(pending), 32'h4);
    check_call("t1_pre", 1'b0, 2'd0);
    step();
    check_call("t1_req", 1'b1, 2'd2);
    ack = 1'b1; step();
    check("t1_ack_pending", 32'(pending), 32'h0);
    check("t1_ack_state",   32'(state),   32'd2);
    check_call("t1_ack", 1'b0, 2'd0);
    ack = 1'b0; irq = '0; step();
    check("t1_service_hold", 32'(state), 32'd2);
    done = 1'b1; step();
    check("t1_done_state", 32'(state), 32'd0);
    done = 1'b0;

    // Channels 1 and 3 together: 1 first, 3 right after done.
    irq = 4'b1010; step();
    check("t2_pending", 32'(pending), 32'hA);
    step();
    check_call("t2_first", 1'b1, 2'd1);
    ack = 1'b1; step();
    check("t2_pending_after_ack", 32'(pending), 32'h8);
    ack = 1'b0; done = 1'b1; step();
    check_call("t2_idle", 1'b0, 2'd0);
    done = 1'b0; step();
    check_call("t2_second", 1'b1, 2'd3);

    // Higher-priority channel 0 arrives while id 3 is requested: id frozen.
    irq = 4'b1011; step();
    check("t3_pending", 32'(pending), 32'h9);
    check_call("t3_frozen", 1'b1, 2'd3);
    ack = 1'b1; step();
    check("t3_pending_after_ack", 32'(pending), 32'h1);
    ack = 1'b0; done = 1'b1; step();
    done = 1'b0; step();
    check_call("t3_ch0", 1'b1, 2'd0);
    ack = 1'b1; step();
    ack = 1'b0; done = 1'b1; step();
    done = 1'b0; irq = '0; step();
    check("t3_clean_pending", 32'(pending), 32'h0);
    check("t3_no_overrun",    32'(overrun), 32'h0);

    // Overrun on channel 1, then an edge coinciding with its ack.
    irq = 4'b0010; step();
    step();
    check_call("t4_req", 1'b1, 2'd1);
    irq = '0; step();
    irq = 4'b0010; step();
    check("t4_overrun", 32'(overrun), 32'h2);
    check("t4_pending", 32'(pending), 32'h2);
    irq = '0; step();
    irq = 4'b0010; ack = 1'b1; step();
    check("t4_ack_edge_pending", 32'(pending), 32'h2);
    check("t4_ack_edge_overrun", 32'(overrun), 32'h2);
    check("t4_ack_edge_state",   32'(state),   32'd2);
    ack = 1'b0; irq = '0; done = 1'b1; step();
    done = 1'b0; step();
    check_call("t4_recall", 1'b1, 2'd1);
    ack = 1'b1; step();
    check("t4_pending_clear", 32'(pending), 32'h0);
    ack = 1'b0; done = 1'b1; step();
    done = 1'b0;
    check("t4_overrun_sticky", 32'(overrun), 32'h2);

    // Masked channel 0: captured but not called until unmasked.
    mask = 4'b1110; irq = 4'b0001; step();
    check("t5_pending", 32'(pending), 32'h1);
    step();
    check_call("t5_masked", 1'b0, 2'd0);
    mask = 4'hF; step();
    check_call("t5_unmasked", 1'b1, 2'd0);
    ack = 1'b1; step();
    ack = 1'b0; irq = '0; done = 1'b1; step();
    done = 1'b0;

    // Stall: no call while disabled; ack ignored while stalled in REQ.
    enable = 1'b0; irq = 4'b0100; step();
    check("t6_pending", 32'(pending), 32'h4);
    step(); step();
    check_call("t6_stalled", 1'b0, 2'd0);
    enable = 1'b1; step();
    check_call("t6_resume", 1'b1, 2'd2);
    enable = 1'b0; ack = 1'b1; step();
    check_call("t6_stall_hold", 1'b1, 2'd2);
    check("t6_stall_pending", 32'(pending), 32'h4);
    enable = 1'b1; step();
    check("t6_ack_state", 32'(state), 32'd2);
    ack = 1'b0; done = 1'b1; step();
    done = 1'b0; irq = '0; step();

    // Reset mid-REQ with channel 1 held high across release.
    irq = 4'b0010; step();
    step();
    check_call("t7_req", 1'b1, 2'd1);
    reset = 1'b1; step();
    check("t7_rst_call",    32'(call),    32'd0);
    check("t7_rst_id",      32'(irq_id),  32'd0);
    check("t7_rst_pending", 32'(pending), 32'h0);
    check("t7_rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0; step();
    check("t7_edge_pending", 32'(pending), 32'h2);
    step();
    check_call("t7_call", 1'b1, 2'd1);
    ack = 1'b1; step();
    check("t7_no_reedge", 32'(pending), 32'h0);
    ack = 1'b0; done = 1'b1; step();
    done = 1'b0; step();
    check_call("t7_quiet", 1'b0, 2'd0);
    irq = '0;

    // Level channel 0 held high: re-called after every done.
    lvl_irq = 4'b0001; step();
    check("t8_pending", 32'(lvl_pending), 32'h1);
    step();
    check("t8_call1", 32'({lvl_call, lvl_id}), 32'h4);
    lvl_ack = 1'b1; step();
    check("t8_pending_held", 32'(lvl_pending), 32'h1);
    check("t8_state_service", 32'(lvl_state), 32'd2);
    lvl_ack = 1'b0; lvl_done = 1'b1; step();
    lvl_done = 1'b0; step();
    check("t8_call2", 32'({lvl_call, lvl_id}), 32'h4);
    lvl_ack = 1'b1; step();
    lvl_ack = 1'b0; lvl_done = 1'b1; step();
    lvl_done = 1'b0; step();
    check("t8_call3", 32'({lvl_call, lvl_id}), 32'h4);
    check("t8_no_overrun", 32'(lvl_overrun), 32'h0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
